// File: rtl/m_serial_subtractor.sv
// Nibble-serial subtract-with-borrow engine: Z = X - Y - BIN, one 4-bit slice per clock.
// Optional feature macro: SUB_SATURATE_EN (clamp an underflowing result to zero).
module m_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Z,
  output logic             BOUT,
  output logic             ZERO
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             b_q, b_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic [3:0]       x_nib_c;
  logic [3:0]       y_nib_c;
  logic [4:0]       diff_c;
  logic [WIDTH-1:0] z_slice_c;

  // One 5-bit slice subtract; bit 4 of the difference is the outgoing borrow.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    b_d     = b_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    zero_d  = zero_q;

    x_nib_c   = x_q[{idx_q, 2'b00} +: 4];
    y_nib_c   = y_q[{idx_q, 2'b00} +: 4];
    diff_c    = {1'b0, x_nib_c} - {1'b0, y_nib_c} - {4'b0000, b_q};
    z_slice_c = z_q;
    z_slice_c[{idx_q, 2'b00} +: 4] = diff_c[3:0];

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          x_d     = X;
          y_d     = Y;
          b_d     = BIN;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        z_d   = z_slice_c;
        b_d   = diff_c[4];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          bout_d  = diff_c[4];
          zero_d  = (z_slice_c == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_IDLE;
`ifdef SUB_SATURATE_EN
          if (diff_c[4]) begin
            z_d    = '0;
            zero_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= 1'b0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Z    = z_q;
  assign BOUT = bout_q;
  assign ZERO = zero_q;

endmodule

// File: tb/tb_m_serial_subtractor.sv
// Randomized and directed bench for m_serial_subtractor (WIDTH=16) against an arithmetic model.
module tb_m_serial_subtractor;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] x, y;
  logic             bin;
  logic             busy, done, bout, zero;
  logic [WIDTH-1:0] z;

  int total;
  int bad;

  m_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .MasterClock(clk),
    .RESET      (rst),
    .START      (start),
    .X          (x),
    .Y          (y),
    .BIN        (bin),
    .BUSY       (busy),
    .DONE       (done),
    .Z          (z),
    .BOUT       (bout),
    .ZERO       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width unsigned subtraction, borrow is the bit above the result.
  task automatic model(input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] my,
                       input logic mb, output logic [WIDTH-1:0] ez,
                       output logic eb, output logic ezero);
    logic [WIDTH:0] full;
    full  = {1'b0, mx} - {1'b0, my} - {{WIDTH{1'b0}}, mb};
    ez    = full[WIDTH-1:0];
    eb    = full[WIDTH];
`ifdef SUB_SATURATE_EN
    if (eb) ez = '0;
`endif
    ezero = (ez == '0);
  endtask

  task automatic launch(input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] my, input logic mb);
    start = 1'b1;
    x     = mx;
    y     = my;
    bin   = mb;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] mx,
                        input logic [WIDTH-1:0] my, input logic mb);
    logic [WIDTH-1:0] ez;
    logic             eb, ezero;
    int               cyc;
    model(mx, my, mb, ez, eb, ezero);
    launch(mx, my, mb);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s busy/done after start: got %b/%b want 1/0", name, busy, done);
    end
    wait_done(cyc);
    total++;
    if (cyc !== NIBBLES) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, NIBBLES);
    end
    total++;
    if (z !== ez || bout !== eb || zero !== ezero || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s result X=%h Y=%h B=%b: got Z=%h BOUT=%b ZERO=%b BUSY=%b want Z=%h BOUT=%b ZERO=%b BUSY=0",
               name, mx, my, mb, z, bout, zero, busy, ez, eb, ezero);
    end
    tick();
    total++;
    if (done !== 1'b0 || z !== ez || bout !== eb || zero !== ezero) begin
      bad++;
      $display("FAIL %s hold after done: got DONE=%b Z=%h BOUT=%b ZERO=%b want DONE=0 Z=%h BOUT=%b ZERO=%b",
               name, done, z, bout, zero, ez, eb, ezero);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== '0 || bout !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL %s outputs: got BUSY=%b DONE=%b Z=%h BOUT=%b ZERO=%b want all 0",
               name, busy, done, z, bout, zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    x = 16'hFFFF;
    y = 16'h0001;
    bin = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_directed();
    run_op("basic",   16'h1234, 16'h0234, 1'b0);
    run_op("underflow", 16'h0000, 16'h0001, 1'b0);
    run_op("ripple",  16'h8000, 16'h7FFF, 1'b1);
    run_op("max_minus_max_b", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("equal",   16'hABCD, 16'hABCD, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_busy_ignore();
    int n_done;
    logic [WIDTH-1:0] z_at_done;
    n_done = 0;
    z_at_done = '0;
    launch(16'h00F0, 16'h0010, 1'b0);
    tick();
    start = 1'b1;
    x = 16'hFFFF;
    y = 16'h0000;
    bin = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        n_done++;
        z_at_done = z;
      end
      tick();
    end
    total++;
    if (n_done !== 1 || z_at_done !== 16'h00E0) begin
      bad++;
      $display("FAIL busy_ignore: got dones=%0d Z=%h want dones=1 Z=00e0", n_done, z_at_done);
    end
    total++;
    if (busy !== 1'b0 || z !== 16'h00E0) begin
      bad++;
      $display("FAIL busy_ignore idle: got BUSY=%b Z=%h want 0/00e0", busy, z);
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    n_done = 0;
    launch(16'h5555, 16'h1111, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort_reset");
    for (int i = 0; i < 8; i++) begin
      if (done) n_done++;
      tick();
    end
    total++;
    if (n_done !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got dones=%0d BUSY=%b want 0/0", n_done, busy);
    end
    run_op("after_abort", 16'h0003, 16'h0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(16'h1234, 16'h0234, 1'b0);
    wait_done(cyc);
    start = 1'b1;
    x = 16'h0010;
    y = 16'h0001;
    bin = 1'b0;
    total++;
    if (done !== 1'b1 || z !== 16'h1000) begin
      bad++;
      $display("FAIL b2b first: got DONE=%b Z=%h want 1/1000", done, z);
    end
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b accept: got DONE=%b BUSY=%b want 0/1", done, busy);
    end
    wait_done(cyc);
    total++;
    if (cyc !== NIBBLES || z !== 16'h000F || bout !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL b2b second: got lat=%0d Z=%h BOUT=%b ZERO=%b want %0d/000f/0/0",
               cyc, z, bout, zero, NIBBLES);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    bin   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
